// File: rtl/msu_audio_out_pkg.sv
`default_nettype none
// msu_pkg: shared constants, FSM encodings and sample arithmetic for the MSU-1 audio path.
// Revision: 1.0
package msu_pkg;

    localparam int SECTOR_SIZE_WORDS = 512;
    localparam int FIFO_DEPTH_WORDS  = 2048;
    localparam int USEDW_W           = $clog2(FIFO_DEPTH_WORDS);

    // Priming threshold is one full sector of PCM words.
    localparam logic [USEDW_W-1:0] PRIME_WORDS_DEFAULT = USEDW_W'(SECTOR_SIZE_WORDS);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_PRIME = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_RD_L  = 3'd3;
    localparam logic [2:0] ST_RD_R  = 3'd4;
    localparam logic [2:0] ST_OUT   = 3'd5;

    // Volume 255 maps to a multiplier of 256 so that full scale is an exact pass-through.
    function automatic logic signed [15:0] msu_scale(input logic signed [15:0] x,
                                                     input logic [7:0] v);
        logic [8:0]         m;
        logic signed [25:0] p;
        m = {1'b0, v} + {8'd0, v[7]};
        p = 26'(x) * 26'($signed({1'b0, m}));
        return p[23:8];
    endfunction

    function automatic logic [7:0] vol_ramp_step(input logic [7:0] cur, input logic [7:0] tgt);
        if (cur < tgt) begin
            return cur + 8'd1;
        end else if (cur > tgt) begin
            return cur - 8'd1;
        end
        return cur;
    endfunction

endpackage
`default_nettype wire

// File: rtl/msu_sample_tick.sv
`default_nettype none
// msu_sample_tick: fractional-accumulator strobe, one tick_o pulse per 1/SAMPLE_HZ on average.
// Revision: 1.0
module msu_sample_tick #(
    parameter int unsigned CLK_HZ    = 21477270,
    parameter int unsigned SAMPLE_HZ = 44100
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic tick_o
);

    logic [31:0] acc_q;
    logic [31:0] acc_d;
    logic [31:0] sum;

    always_comb begin
        sum    = acc_q + SAMPLE_HZ;
        tick_o = (sum >= CLK_HZ);
        acc_d  = tick_o ? (sum - CLK_HZ) : sum;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/msu_audio_out.sv
`default_nettype none
// msu_audio_out: pops L/R PCM pairs from the MSU-1 FIFO at 44.1 kHz, applies volume, drives the mixer.
// Build option: define MSU_AUDIO_VOLRAMP_EN for a one-step-per-sample volume ramp. Revision: 1.0
module msu_audio_out
    import msu_pkg::*;
#(
    parameter int unsigned        CLK_HZ      = 21477270,
    parameter int unsigned        SAMPLE_HZ   = 44100,
    parameter logic [USEDW_W-1:0] PRIME_WORDS = PRIME_WORDS_DEFAULT
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                audio_play,
    input  logic                clear,
    input  logic [7:0]          volume,
    input  logic signed [15:0]  fifo_q,
    input  logic [USEDW_W-1:0]  fifo_usedw,
    output logic                fifo_rd,
    output logic signed [15:0]  audio_l,
    output logic signed [15:0]  audio_r,
    output logic                sample_valid,
    output logic                underrun
);

`ifdef MSU_AUDIO_VOLRAMP_EN
    localparam bit VOL_RAMP = 1'b1;
`else
    localparam bit VOL_RAMP = 1'b0;
`endif

    localparam logic [USEDW_W-1:0] PAIR_WORDS = USEDW_W'(2);

    if (CLK_HZ < 8 * SAMPLE_HZ) begin : g_ratio_check
        $error("msu_audio_out: CLK_HZ must be at least 8*SAMPLE_HZ");
    end

    logic tick;

    msu_sample_tick #(
        .CLK_HZ    (CLK_HZ),
        .SAMPLE_HZ (SAMPLE_HZ)
    ) u_tick (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .tick_o (tick)
    );

    logic [2:0]         state_q, state_d;
    logic signed [15:0] left_q, left_d;
    logic signed [15:0] audio_l_q, audio_l_d;
    logic signed [15:0] audio_r_q, audio_r_d;
    logic               sample_valid_q, sample_valid_d;
    logic               underrun_q, underrun_d;
    logic [7:0]         vcur_q, vcur_d;
    logic               rd;

    always_comb begin
        state_d        = state_q;
        left_d         = left_q;
        audio_l_d      = audio_l_q;
        audio_r_d      = audio_r_q;
        sample_valid_d = 1'b0;
        underrun_d     = underrun_q;
        vcur_d         = VOL_RAMP ? vcur_q : volume;
        rd             = 1'b0;

        if (clear) begin
            state_d    = ST_IDLE;
            audio_l_d  = '0;
            audio_r_d  = '0;
            underrun_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    audio_l_d = '0;
                    audio_r_d = '0;
                    if (audio_play) begin
                        state_d    = ST_PRIME;
                        underrun_d = 1'b0;
                    end
                end
                ST_PRIME: begin
                    if (!audio_play) begin
                        state_d = ST_IDLE;
                    end else if (fifo_usedw >= PRIME_WORDS) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // A tick always wins over a pause so an accepted tick yields a full pair.
                    if (tick) begin
                        if (fifo_usedw >= PAIR_WORDS) begin
                            rd      = 1'b1;
                            state_d = ST_RD_L;
                        end else begin
                            underrun_d     = 1'b1;
                            audio_l_d      = '0;
                            audio_r_d      = '0;
                            sample_valid_d = 1'b1;
                            if (VOL_RAMP) begin
                                vcur_d = vol_ramp_step(vcur_q, volume);
                            end
                        end
                    end else if (!audio_play) begin
                        state_d   = ST_IDLE;
                        audio_l_d = '0;
                        audio_r_d = '0;
                    end
                end
                ST_RD_L: begin
                    left_d  = fifo_q;
                    rd      = 1'b1;
                    state_d = ST_RD_R;
                end
                ST_RD_R: begin
                    // Outputs register here so they are presented during the OUT cycle.
                    audio_l_d      = msu_scale(left_q, vcur_q);
                    audio_r_d      = msu_scale(fifo_q, vcur_q);
                    sample_valid_d = 1'b1;
                    state_d        = ST_OUT;
                end
                ST_OUT: begin
                    if (VOL_RAMP) begin
                        vcur_d = vol_ramp_step(vcur_q, volume);
                    end
                    if (audio_play) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d   = ST_IDLE;
                        audio_l_d = '0;
                        audio_r_d = '0;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    audio_l_d = '0;
                    audio_r_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            left_q         <= '0;
            audio_l_q      <= '0;
            audio_r_q      <= '0;
            sample_valid_q <= 1'b0;
            underrun_q     <= 1'b0;
            vcur_q         <= '0;
        end else begin
            state_q        <= state_d;
            left_q         <= left_d;
            audio_l_q      <= audio_l_d;
            audio_r_q      <= audio_r_d;
            sample_valid_q <= sample_valid_d;
            underrun_q     <= underrun_d;
            vcur_q         <= vcur_d;
        end
    end

    assign fifo_rd      = rd;
    assign audio_l      = audio_l_q;
    assign audio_r      = audio_r_q;
    assign sample_valid = sample_valid_q;
    assign underrun     = underrun_q;

endmodule
`default_nettype wire
